// File: rtl/video_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// video_frame_ctrl_if
// Monitor tap on the video IP's Avalon-ST sink, plus the stream gate that
// goes back from the frame controller.
//   mon_valid     : valid at the IP sink
//   mon_ready     : ready at the IP sink, before gating
//   mon_sop       : startofpacket at the IP sink
//   mon_eop       : endofpacket at the IP sink
//   stream_enable : the top level ANDs this into ready_out and valid_out
// Modports:
//   master : the stream side (drives the monitor taps, sees the gate)
//   slave  : the frame controller (watches the taps, drives the gate)
// ---------------------------------------------------------------------------
interface video_frame_ctrl_if;
  logic mon_valid;
  logic mon_ready;
  logic mon_sop;
  logic mon_eop;
  logic stream_enable;

  modport master (
    output mon_valid,
    output mon_ready,
    output mon_sop,
    output mon_eop,
    input  stream_enable
  );

  modport slave (
    input  mon_valid,
    input  mon_ready,
    input  mon_sop,
    input  mon_eop,
    output stream_enable
  );
endinterface

// File: rtl/video_frame_ctrl.sv
// ---------------------------------------------------------------------------
// video_frame_ctrl
// Frame-level controller for the video IP stream path. It watches accepted
// beats on the IP sink, tracks frame boundaries, freezes the effect
// configuration for the duration of each frame, carries out pause requests
// at frame boundaries, counts pixels and frames, raises the end-of-frame
// interrupt and flags framing errors.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   mon (slave)         : sink monitor taps in, stream_enable out
//   pause_req           : hold the stream at the next frame boundary
//   irq_enable          : allow frame ends to set irq
//   irq_clear           : one-cycle pulse, clears irq
//   err_clear           : one-cycle pulse, clears sop_err and orphan_err
//   cfg_*               : live effect configuration from the registers
//   act_*               : frozen configuration seen by video_effects
//   irq                 : sticky end-of-frame interrupt (level)
//   state               : 00 IDLE, 01 IN_FRAME, 10 PAUSED
//   frame_count         : completed frames (wrapping)
//   pixel_count         : beats accepted in the current frame (saturating)
//   last_frame_pixels   : size of the last completed frame (saturating)
//   sop_err             : sticky, SOP accepted inside a frame
//   orphan_err          : sticky, non-SOP beat accepted in IDLE
//
// State table:
//   state    | meaning
//   IDLE     | between frames, config tracks registers, waiting for SOP
//   IN_FRAME | frame in progress, config frozen
//   PAUSED   | stream gated off, config tracks registers
// ---------------------------------------------------------------------------
module video_frame_ctrl #(
  parameter int PIX_CNT_W   = 20,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  video_frame_ctrl_if.slave      mon,
  input  logic                   pause_req,
  input  logic                   irq_enable,
  input  logic                   irq_clear,
  input  logic                   err_clear,
  input  logic [4:0]             cfg_effect,
  input  logic [1:0]             cfg_delete_rgb,
  input  logic [1:0]             cfg_quantif,
  input  logic [15:0]            cfg_color_key,
  input  logic [15:0]            cfg_color_mask,
  input  logic [15:0]            cfg_color_sub,
  output logic [4:0]             act_effect,
  output logic [1:0]             act_delete_rgb,
  output logic [1:0]             act_quantif,
  output logic [15:0]            act_color_key,
  output logic [15:0]            act_color_mask,
  output logic [15:0]            act_color_sub,
  output logic                   irq,
  output logic [1:0]             state,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [PIX_CNT_W-1:0]   pixel_count,
  output logic [PIX_CNT_W-1:0]   last_frame_pixels,
  output logic                   sop_err,
  output logic                   orphan_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IN_FRAME = 2'b01,
    ST_PAUSED   = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [PIX_CNT_W-1:0]   pix_q, pix_d;
  logic [PIX_CNT_W-1:0]   last_q, last_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   irq_q, irq_d;
  logic                   sop_err_q, sop_err_d;
  logic                   orphan_err_q, orphan_err_d;

  logic [4:0]             act_effect_q;
  logic [1:0]             act_delete_rgb_q;
  logic [1:0]             act_quantif_q;
  logic [15:0]            act_color_key_q;
  logic [15:0]            act_color_mask_q;
  logic [15:0]            act_color_sub_q;

  logic                   stream_en;
  logic                   acc;
  logic                   frame_end;
  logic [PIX_CNT_W-1:0]   end_size;
  logic [PIX_CNT_W-1:0]   pix_inc;
  logic                   sop_err_set;
  logic                   orphan_set;
  logic                   cfg_load;

  // The gate is a pure function of state: only PAUSED blocks the stream.
  assign stream_en         = (state_q != ST_PAUSED);
  assign mon.stream_enable = stream_en;

  assign acc = mon.mon_valid & mon.mon_ready & stream_en;

  // Saturating increment of the running pixel count.
  assign pix_inc = (&pix_q) ? pix_q : pix_q + PIX_CNT_W'(1);

  // Configuration follows the registers everywhere except inside a frame.
  // The SOP cycle in IDLE still loads, so the frame uses that cycle's values.
  assign cfg_load = (state_q != ST_IN_FRAME);

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    last_d      = last_q;
    fcnt_d      = fcnt_q;
    frame_end   = 1'b0;
    end_size    = '0;
    sop_err_set = 1'b0;
    orphan_set  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (acc && mon.mon_sop) begin
          // An accepted SOP wins over a pending pause; the pause is
          // honoured at the end of this frame instead.
          pix_d = PIX_CNT_W'(1);
          if (mon.mon_eop) begin
            frame_end = 1'b1;
            end_size  = PIX_CNT_W'(1);
          end else begin
            state_d = ST_IN_FRAME;
          end
        end else begin
          if (acc) begin
            orphan_set = 1'b1;
          end
          if (pause_req) begin
            state_d = ST_PAUSED;
          end
        end
      end

      ST_IN_FRAME: begin
        if (acc) begin
          if (mon.mon_sop) begin
            // Restart: the partial frame is dropped, not counted.
            sop_err_set = 1'b1;
            pix_d       = PIX_CNT_W'(1);
            if (mon.mon_eop) begin
              frame_end = 1'b1;
              end_size  = PIX_CNT_W'(1);
            end
          end else if (mon.mon_eop) begin
            frame_end = 1'b1;
            end_size  = pix_inc;
          end else begin
            pix_d = pix_inc;
          end
        end
      end

      ST_PAUSED: begin
        if (!pause_req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_end) begin
      pix_d   = end_size;
      last_d  = end_size;
      fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
      state_d = pause_req ? ST_PAUSED : ST_IDLE;
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_comb begin
    irq_d        = (frame_end & irq_enable) | (irq_q & ~irq_clear);
    sop_err_d    = sop_err_set | (sop_err_q & ~err_clear);
    orphan_err_d = orphan_set | (orphan_err_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pix_q        <= '0;
      last_q       <= '0;
      fcnt_q       <= '0;
      irq_q        <= 1'b0;
      sop_err_q    <= 1'b0;
      orphan_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      last_q       <= last_d;
      fcnt_q       <= fcnt_d;
      irq_q        <= irq_d;
      sop_err_q    <= sop_err_d;
      orphan_err_q <= orphan_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      act_effect_q     <= '0;
      act_delete_rgb_q <= '0;
      act_quantif_q    <= '0;
      act_color_key_q  <= '0;
      act_color_mask_q <= '0;
      act_color_sub_q  <= '0;
    end else if (cfg_load) begin
      act_effect_q     <= cfg_effect;
      act_delete_rgb_q <= cfg_delete_rgb;
      act_quantif_q    <= cfg_quantif;
      act_color_key_q  <= cfg_color_key;
      act_color_mask_q <= cfg_color_mask;
      act_color_sub_q  <= cfg_color_sub;
    end
  end

  assign act_effect        = act_effect_q;
  assign act_delete_rgb    = act_delete_rgb_q;
  assign act_quantif       = act_quantif_q;
  assign act_color_key     = act_color_key_q;
  assign act_color_mask    = act_color_mask_q;
  assign act_color_sub     = act_color_sub_q;

  assign irq               = irq_q;
  assign state             = state_q;
  assign frame_count       = fcnt_q;
  assign pixel_count       = pix_q;
  assign last_frame_pixels = last_q;
  assign sop_err           = sop_err_q;
  assign orphan_err        = orphan_err_q;

endmodule

// File: tb/tb_video_frame_ctrl.sv
module tb_video_frame_ctrl;

  // Narrow counters so saturation and wrap are reachable in a short run.
  localparam int PW   = 6;
  localparam int FW   = 4;
  localparam int PMAX = (1 << PW) - 1;
  localparam int FMOD = (1 << FW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          pause_req, irq_enable, irq_clear, err_clear;
  logic [4:0]    cfg_effect;
  logic [1:0]    cfg_delete_rgb, cfg_quantif;
  logic [15:0]   cfg_color_key, cfg_color_mask, cfg_color_sub;
  logic [4:0]    act_effect;
  logic [1:0]    act_delete_rgb, act_quantif;
  logic [15:0]   act_color_key, act_color_mask, act_color_sub;
  logic          irq, sop_err, orphan_err;
  logic [1:0]    state;
  logic [FW-1:0] frame_count;
  logic [PW-1:0] pixel_count, last_frame_pixels;

  video_frame_ctrl_if mon();

  video_frame_ctrl #(.PIX_CNT_W(PW), .FRAME_CNT_W(FW)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .mon               (mon.slave),
    .pause_req         (pause_req),
    .irq_enable        (irq_enable),
    .irq_clear         (irq_clear),
    .err_clear         (err_clear),
    .cfg_effect        (cfg_effect),
    .cfg_delete_rgb    (cfg_delete_rgb),
    .cfg_quantif       (cfg_quantif),
    .cfg_color_key     (cfg_color_key),
    .cfg_color_mask    (cfg_color_mask),
    .cfg_color_sub     (cfg_color_sub),
    .act_effect        (act_effect),
    .act_delete_rgb    (act_delete_rgb),
    .act_quantif       (act_quantif),
    .act_color_key     (act_color_key),
    .act_color_mask    (act_color_mask),
    .act_color_sub     (act_color_sub),
    .irq               (irq),
    .state             (state),
    .frame_count       (frame_count),
    .pixel_count       (pixel_count),
    .last_frame_pixels (last_frame_pixels),
    .sop_err           (sop_err),
    .orphan_err        (orphan_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame status held as plain integers.
  // m_mode: 0 between frames, 1 inside a frame, 2 paused.
  int m_mode, m_pc, m_last, m_fc;
  bit m_irq, m_serr, m_oerr;
  int m_eff, m_drgb, m_quant, m_key, m_mask, m_sub;

  function automatic int sat_inc(input int v);
    return (v >= PMAX) ? PMAX : v + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expv);
    checks++;
    if (actual !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expv, $time);
    end
  endtask

  task automatic model_step();
    int  prev;
    bit  acc, fend, sset, oset;
    int  size;
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_last = 0; m_fc = 0;
      m_irq = 0; m_serr = 0; m_oerr = 0;
      m_eff = 0; m_drgb = 0; m_quant = 0; m_key = 0; m_mask = 0; m_sub = 0;
      return;
    end
    prev = m_mode;
    acc  = mon.mon_valid && mon.mon_ready && (prev != 2);
    fend = 0; sset = 0; oset = 0; size = 0;
    if (prev != 1) begin
      m_eff = int'(cfg_effect); m_drgb = int'(cfg_delete_rgb); m_quant = int'(cfg_quantif);
      m_key = int'(cfg_color_key); m_mask = int'(cfg_color_mask); m_sub = int'(cfg_color_sub);
    end
    if (prev == 2) begin
      if (!pause_req) m_mode = 0;
    end else if (acc && mon.mon_sop) begin
      if (prev == 1) sset = 1;
      if (mon.mon_eop) begin
        fend = 1; size = 1;
      end else begin
        m_mode = 1; m_pc = 1;
      end
    end else if (acc && prev == 1) begin
      if (mon.mon_eop) begin
        fend = 1; size = sat_inc(m_pc);
      end else begin
        m_pc = sat_inc(m_pc);
      end
    end else begin
      if (acc) oset = 1;
      if (prev == 0 && pause_req) m_mode = 2;
    end
    if (fend) begin
      m_fc   = (m_fc + 1) % FMOD;
      m_last = size;
      m_pc   = size;
      m_mode = pause_req ? 2 : 0;
    end
    m_irq  = (fend && irq_enable) || (m_irq && !irq_clear);
    m_serr = sset || (m_serr && !err_clear);
    m_oerr = oset || (m_oerr && !err_clear);
  endtask

  task automatic compare_all();
    chk("state",       32'(state),             m_mode);
    chk("stream_en",   32'(mon.stream_enable), (m_mode == 2) ? 0 : 1);
    chk("pixel_count", 32'(pixel_count),       m_pc);
    chk("last_pixels", 32'(last_frame_pixels), m_last);
    chk("frame_count", 32'(frame_count),       m_fc);
    chk("irq",         32'(irq),               32'(m_irq));
    chk("sop_err",     32'(sop_err),           32'(m_serr));
    chk("orphan_err",  32'(orphan_err),        32'(m_oerr));
    chk("act_effect",  32'(act_effect),        m_eff);
    chk("act_delrgb",  32'(act_delete_rgb),    m_drgb);
    chk("act_quantif", 32'(act_quantif),       m_quant);
    chk("act_key",     32'(act_color_key),     m_key);
    chk("act_mask",    32'(act_color_mask),    m_mask);
    chk("act_sub",     32'(act_color_sub),     m_sub);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic r, input logic s, input logic e);
    mon.mon_valid = v; mon.mon_ready = r; mon.mon_sop = s; mon.mon_eop = e;
  endtask

  task automatic beat(input logic s, input logic e);
    drive(1'b1, 1'b1, s, e);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    pause_req = 0; irq_clear = 0; err_clear = 0;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic v, r, sop, eop, iclr, eclr;
    int   st, pc, fc, last;
    logic irq, oerr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic r, input logic s, input logic e,
                              input logic ic, input logic ec, input int st, input int pc,
                              input int fc, input int last, input logic iq, input logic oe);
    vec_t t;
    t.v = v; t.r = r; t.sop = s; t.eop = e; t.iclr = ic; t.eclr = ec;
    t.st = st; t.pc = pc; t.fc = fc; t.last = last; t.irq = iq; t.oerr = oe;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    //           v  r  sop eop iclr eclr st pc fc last irq oerr
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 1, 0, 0, 0, 4, 1, 4, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, 4, 1, 4, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0, 4, 1, 4, 0, 1);
    tbl[6]  = mk(1, 1, 1, 1, 0, 0, 0, 1, 2, 1, 1, 1);
    tbl[7]  = mk(1, 1, 1, 1, 1, 0, 0, 1, 3, 1, 1, 1);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 3, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 3, 1, 1, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 1, 0, 1, 3, 1, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 1, 3, 1, 0, 0);

    irq_enable = 1; cfg_effect = 0; cfg_delete_rgb = 0; cfg_quantif = 0;
    cfg_color_key = 0; cfg_color_mask = 0; cfg_color_sub = 0;
    do_reset();
    chk("rst.state", 32'(state), 0);
    chk("rst.stream_en", 32'(mon.stream_enable), 1);

    // Frame basics, irq set/clear, orphan beat, single-beat frames, gated beats.
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].sop, tbl[i].eop);
      irq_clear = tbl[i].iclr; err_clear = tbl[i].eclr;
      cycle();
      chk($sformatf("tbl%0d.state", i), 32'(state), tbl[i].st);
      chk($sformatf("tbl%0d.pc", i), 32'(pixel_count), tbl[i].pc);
      chk($sformatf("tbl%0d.fc", i), 32'(frame_count), tbl[i].fc);
      chk($sformatf("tbl%0d.last", i), 32'(last_frame_pixels), tbl[i].last);
      chk($sformatf("tbl%0d.irq", i), 32'(irq), 32'(tbl[i].irq));
      chk($sformatf("tbl%0d.oerr", i), 32'(orphan_err), 32'(tbl[i].oerr));
    end
    drive(0, 0, 0, 0); irq_clear = 0; err_clear = 0;

    // Config freeze across a frame.
    do_reset();
    cfg_effect = 5'h01;
    beat(1, 0);
    chk("cfg.at_sop", 32'(act_effect), 32'h01);
    beat(0, 0);
    cfg_effect = 5'h10;
    beat(0, 0);
    chk("cfg.frozen", 32'(act_effect), 32'h01);
    beat(0, 1);
    chk("cfg.at_eop", 32'(act_effect), 32'h01);
    cycle();
    chk("cfg.after", 32'(act_effect), 32'h10);

    // Pause requested mid-frame takes effect at the frame end.
    do_reset();
    beat(1, 0);
    pause_req = 1;
    beat(0, 0);
    beat(0, 0);
    beat(0, 0);
    chk("pause.mid_en", 32'(mon.stream_enable), 1);
    beat(0, 1);
    chk("pause.state", 32'(state), 2);
    chk("pause.en", 32'(mon.stream_enable), 0);
    chk("pause.last", 32'(last_frame_pixels), 5);
    drive(1, 1, 1, 0);
    repeat (3) cycle();
    chk("pause.held_pc", 32'(pixel_count), 5);
    pause_req = 0;
    cycle();
    chk("pause.release", 32'(state), 0);
    cycle();
    chk("pause.sop_in", 32'(state), 1);
    chk("pause.sop_pc", 32'(pixel_count), 1);
    drive(0, 0, 0, 0);

    // Second SOP inside a frame.
    do_reset();
    beat(1, 0); beat(0, 0); beat(0, 0);
    beat(1, 0);
    chk("sop2.err", 32'(sop_err), 1);
    chk("sop2.pc", 32'(pixel_count), 1);
    chk("sop2.fc", 32'(frame_count), 0);
    beat(0, 0); beat(0, 1);
    chk("sop2.last", 32'(last_frame_pixels), 3);

    // Pixel counter saturation.
    do_reset();
    beat(1, 0);
    repeat (PMAX + 5) beat(0, 0);
    chk("sat.pc", 32'(pixel_count), PMAX);
    beat(0, 1);
    chk("sat.last", 32'(last_frame_pixels), PMAX);

    // Reset mid-frame discards everything.
    do_reset();
    beat(1, 1);
    beat(1, 0);
    repeat (6) beat(0, 0);
    chk("rmid.pc7", 32'(pixel_count), 7);
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rmid.state", 32'(state), 0);
    chk("rmid.pc", 32'(pixel_count), 0);
    chk("rmid.fc", 32'(frame_count), 0);
    chk("rmid.irq", 32'(irq), 0);
    chk("rmid.last", 32'(last_frame_pixels), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      int eop_div;
      eop_div = (i < 2500) ? 8 : 90;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, eop_div - 1) == 0));
      if ($urandom_range(0, 29) == 0) pause_req = ~pause_req;
      irq_enable = 1'($urandom_range(0, 4) != 0);
      irq_clear  = 1'($urandom_range(0, 15) == 0);
      err_clear  = 1'($urandom_range(0, 31) == 0);
      cfg_effect     = 5'($urandom);
      cfg_delete_rgb = 2'($urandom);
      cfg_quantif    = 2'($urandom);
      cfg_color_key  = 16'($urandom);
      cfg_color_mask = 16'($urandom);
      cfg_color_sub  = 16'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_frame_ctrl.md
Name: video_frame_ctrl

Overview:
Frame-level controller for the video IP stream path. It watches the accepted beats on the IP's Avalon-ST sink and tracks frame boundaries. It freezes the effect configuration from the Avalon-MM registers for the whole of each frame, so settings change only between frames. It also carries out pause requests at frame boundaries, counts pixels and frames, raises the end-of-frame interrupt, and flags framing errors.

Parameters:
PIX_CNT_W, 20, width of pixel counters (saturating)
FRAME_CNT_W, 16, width of frame counter (wrapping)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
mon_valid  in  1  valid at IP sink
mon_ready  in  1  ready at IP sink, before gating
mon_sop  in  1  startofpacket at IP sink
mon_eop  in  1  endofpacket at IP sink
pause_req  in  1  reg0[0]
irq_enable  in  1  reg0[1]
irq_clear  in  1  one-cycle pulse, clears irq
err_clear  in  1  one-cycle pulse, clears sop_err and orphan_err
cfg_effect  in  5  reg1[4:0]
cfg_delete_rgb  in  2  reg1[9:8]
cfg_quantif  in  2  reg1[17:16]
cfg_color_key  in  16  reg2[31:16]
cfg_color_mask  in  16  reg2[15:0]
cfg_color_sub  in  16  reg3[15:0]
act_effect, act_delete_rgb, act_quantif, act_color_key, act_color_mask, act_color_sub  out  5/2/2/16/16/16  frozen config to video_effects
stream_enable  out  1  top ANDs this into ready_out and valid_out
irq  out  1  end-of-frame interrupt, level, sticky
state  out  2  00 IDLE, 01 IN_FRAME, 10 PAUSED
frame_count  out  FRAME_CNT_W  completed frames
pixel_count  out  PIX_CNT_W  beats accepted in the current frame
last_frame_pixels  out  PIX_CNT_W  size of the last completed frame
sop_err  out  1  sticky: SOP accepted inside a frame
orphan_err  out  1  sticky: non-SOP beat accepted in IDLE

Behaviour:
- acc = mon_valid & mon_ready & stream_enable. All logic is registered on the clk rising edge.
- Reset (reset==0): state IDLE; stream_enable 1; all act_* 0; irq, sop_err, orphan_err 0; all counters 0.
- Config shadowing:
  - In IDLE and PAUSED: act_* <= cfg_* every cycle (1-cycle latency).
  - In IN_FRAME: act_* hold.
  - The config sampled on the cycle of an accepted SOP in IDLE applies to the whole of that frame.
- IDLE:
  - acc & sop & !eop: -> IN_FRAME; pixel_count <= 1.
  - acc & sop & eop (1-pixel frame): stay IDLE, or go PAUSED if pause_req; frame-end actions apply with size 1.
  - acc & !sop: orphan_err <= 1; stay IDLE; no count.
  - !acc-with-sop & pause_req: -> PAUSED; stream_enable <= 0.
  - An accepted SOP takes priority over pause; the pause is deferred to the end of that frame.
- IN_FRAME:
  - acc & !sop & !eop: pixel_count <= pixel_count+1, saturating at all-ones.
  - acc & sop: sop_err <= 1; the frame restarts with pixel_count <= 1. No frame_count increment. If eop is also set, it is treated as a 1-pixel frame end.
  - acc & eop (no sop): frame end; last_frame_pixels <= sat(pixel_count+1). Next state PAUSED if pause_req, else IDLE.
  - pause_req has no effect mid-frame; stream_enable stays 1.
- Frame-end actions (any frame end):
  - frame_count <= frame_count+1, wrapping to 0.
  - If irq_enable: irq <= 1.
  - pixel_count holds its final value until the next SOP.
- PAUSED:
  - stream_enable = 0, so no beats are accepted.
  - pause_req==0: -> IDLE; stream_enable <= 1.
- irq:
  - irq_clear clears irq.
  - If a set and a clear occur in the same cycle, the set wins.
  - Clearing irq_enable does not clear a pending irq.
- err_clear clears both sticky flags. A same-cycle set wins.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded without being counted.
- Beats with mon_ready=0 or mon_valid=0 have no effect on any state.

Test Plan:
1. Reset, then a 4-beat frame (SOP, 2 mid beats, EOP), irq_enable=1 -> pixel_count 1,2,3; last_frame_pixels=4; frame_count=1; irq=1 the cycle after EOP. irq_clear -> irq=0.
2. cfg_effect=0x01 at SOP. Write 0x10 after beat 2. -> act_effect stays 0x01 through EOP; it reads 0x10 one cycle after return to IDLE.
3. pause_req=1 at beat 2 of a 5-beat frame -> all 5 beats accepted, then state=PAUSED and stream_enable=0. While paused, a held valid+SOP is not counted. pause_req=0 -> IDLE, and that SOP is accepted next.
4. Second SOP mid-frame after 3 beats -> sop_err=1, pixel_count=1, frame_count unchanged. Next EOP after 2 more beats -> last_frame_pixels=3.
5. Non-SOP beat in IDLE -> orphan_err=1, counters unchanged. A SOP+EOP single beat -> frame_count+1, last_frame_pixels=1, state IDLE.
6. reset low mid-frame with pixel_count=7 -> all outputs at reset values the next cycle; irq=0 and frame_count=0.
